multiport_reg_file: RTL and testbench

MULTIPORT_REG_FILE -- requirements
Module: multiport_reg_file

---
 rtl/multiport_reg_file.sv | 160 ++++++++++++++++
 tb/tb_multiport_reg_file.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiport_reg_file.sv
// Two-read / one-write register file with a busy scoreboard.
// After reset the file sweeps every entry to zero (CLEAR) before it accepts
// writes or reservations (READY). Reads are combinational, with optional
// same-cycle write forwarding and an optional hard-wired zero register.
module multiport_reg_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic [ADDR_W-1:0] wr,
  input  logic [DATA_W-1:0] wd,
  input  logic              we,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [DATA_W-1:0] rda,
  output logic [DATA_W-1:0] rdb,
  output logic              busy_a,
  output logic              busy_b,
  output logic              ready
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int NPORTS = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    busy_vec;

  // File is usable only once the sweep has finished and reset is not held;
  // every read-side output is forced to zero otherwise.
  logic active;
  logic wr_ok;
  logic rsv_ok;

  // Register 0 is hard-wired to zero when ZERO_REG is set.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign active = (state_q == READY) && !rst;
  assign wr_ok  = active && we && !is_zero_reg(wr);
  assign rsv_ok = active && rsv_en && !is_zero_reg(rsv_addr);
  assign ready  = active;

  // Clear-sweep FSM: walk cnt over every entry, then park in READY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= READY;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        READY: begin
          state_q <= READY;
        end
        default: begin
          state_q <= CLEAR;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Storage array: zeroed one entry per cycle by the sweep, otherwise written
  // by the write port. Reset alone never touches the contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem[cnt_q] <= '0;
      end else if (wr_ok) begin
        mem[wr] <= wd;
      end
    end
  end

  // One scoreboard bit per register; a reservation on the same edge as a
  // write to that register takes priority so the entry stays busy.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_busy
      if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
        assign busy_vec[gi] = 1'b0;
      end else begin : g_bit
        logic busy_q;

        // Set on reservation, cleared on write-back, cleared by reset.
        always_ff @(posedge clk) begin
          if (rst) begin
            busy_q <= 1'b0;
          end else if (rsv_ok && (rsv_addr == ADDR_W'(gi))) begin
            busy_q <= 1'b1;
          end else if (wr_ok && (wr == ADDR_W'(gi))) begin
            busy_q <= 1'b0;
          end
        end

        assign busy_vec[gi] = busy_q;
      end
    end
  endgenerate

  // Read ports share one implementation; index 0 is port A, 1 is port B.
  logic [NPORTS*DATA_W-1:0] rd_data_flat;
  logic [NPORTS-1:0]        rd_busy_flat;

  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              busy;
      logic              fwd;

      assign addr = (gi == 0) ? ra : rb;
      assign fwd  = (BYPASS != 0) && we && (wr == addr);

      // Zero register beats forwarding; forwarding beats the stored value.
      // A forwarded register reads not-busy unless it is also being
      // reserved this cycle, in which case the stored busy bit is shown.
      always_comb begin
        data = '0;
        busy = 1'b0;
        if (active && !is_zero_reg(addr)) begin
          if (fwd) begin
            data = wd;
            busy = (rsv_en && (rsv_addr == addr)) ? busy_vec[addr] : 1'b0;
          end else begin
            data = mem[addr];
            busy = busy_vec[addr];
          end
        end
      end

      assign rd_data_flat[gi*DATA_W +: DATA_W] = data;
      assign rd_busy_flat[gi]                  = busy;
    end
  endgenerate

  assign rda    = rd_data_flat[0 +: DATA_W];
  assign rdb    = rd_data_flat[DATA_W +: DATA_W];
  assign busy_a = rd_busy_flat[0];
  assign busy_b = rd_busy_flat[1];

endmodule

// File: tb/tb_multiport_reg_file.sv
// Scoreboard bench for multiport_reg_file: expected outputs are queued when
// inputs are driven and compared once the combinational outputs settle.
module tb_multiport_reg_file;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ra, rb, wr, rsv_addr;
  logic [DW-1:0] wd;
  logic          we, rsv_en;
  logic [DW-1:0] rda, rdb;
  logic          busy_a, busy_b, ready;

  multiport_reg_file #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .ZERO_REG(1),
    .BYPASS  (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ra      (ra),
    .rb      (rb),
    .wr      (wr),
    .wd      (wd),
    .we      (we),
    .rsv_en  (rsv_en),
    .rsv_addr(rsv_addr),
    .rda     (rda),
    .rdb     (rdb),
    .busy_a  (busy_a),
    .busy_b  (busy_b),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  localparam int S_RDA = 0, S_RDB = 1, S_BA = 2, S_BB = 3, S_RDY = 4;

  typedef struct {
    string         tag;
    int            sig;
    logic [DW-1:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   txn   = 0;

  // Reference model, enabled once the file is known to be all zero.
  bit            model_on = 1'b0;
  logic [DW-1:0] mem_m [DEPTH];
  logic          busy_m[DEPTH];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] observe(input int sig);
    case (sig)
      S_RDA:   return rda;
      S_RDB:   return rdb;
      S_BA:    return {{(DW-1){1'b0}}, busy_a};
      S_BB:    return {{(DW-1){1'b0}}, busy_b};
      default: return {{(DW-1){1'b0}}, ready};
    endcase
  endfunction

  task automatic expect_out(input string tag, input int sig, input logic [DW-1:0] exp);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = exp;
    sb.push_back(e);
  endtask

  // Let the combinational outputs settle, then drain the scoreboard.
  task automatic compare_now();
    exp_t e;
    #2;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sig), e.exp);
    end
  endtask

  task automatic model_edge();
    if (we && wr != '0) begin
      mem_m[wr]  = wd;
      busy_m[wr] = 1'b0;
    end
    if (rsv_en && rsv_addr != '0) busy_m[rsv_addr] = 1'b1;
  endtask

  // Expected read-port values from the model for the current inputs.
  task automatic expect_model();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          b;
    for (int p = 0; p < 2; p++) begin
      a = (p == 0) ? ra : rb;
      if (a == '0) begin
        d = '0;
        b = 1'b0;
      end else if (we && wr == a) begin
        d = wd;
        b = 1'b0;
      end else begin
        d = mem_m[a];
        b = busy_m[a];
      end
      expect_out((p == 0) ? "rnd_rda" : "rnd_rdb", (p == 0) ? S_RDA : S_RDB, d);
      expect_out((p == 0) ? "rnd_busy_a" : "rnd_busy_b", (p == 0) ? S_BA : S_BB, {{(DW-1){1'b0}}, b});
    end
    expect_out("rnd_ready", S_RDY, 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (model_on) model_edge();
    @(negedge clk);
    txn++;
    $display("txn %0d rst=%0b ra=%0d rb=%0d we=%0b wr=%0d wd=%h rsv=%0b@%0d rda=%h rdb=%h ba=%0b bb=%0b rdy=%0b",
             txn, rst, ra, rb, we, wr, wd, rsv_en, rsv_addr, rda, rdb, busy_a, busy_b, ready);
  endtask

  task automatic idle();
    we = 1'b0;
    rsv_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ra = '0; rb = '0; wr = '0; wd = '0; we = 1'b0; rsv_en = 1'b0; rsv_addr = '0;

    // Reset held for two edges: everything reads zero, writes ignored.
    @(negedge clk);
    we = 1'b1; wr = 5'd4; wd = 32'h1234; ra = 5'd4;
    expect_out("rst_ready", S_RDY, 32'd0);
    expect_out("rst_rda", S_RDA, 32'd0);
    expect_out("rst_busy_a", S_BA, 32'd0);
    compare_now();
    tick();
    idle();
    rst = 1'b0;

    // Sweep: ready low before each of edges 1..32, high after edge 32.
    for (int k = 1; k <= DEPTH; k++) begin
      ra = AW'(k - 1);
      expect_out("clr_ready", S_RDY, 32'd0);
      expect_out("clr_rda", S_RDA, 32'd0);
      compare_now();
      tick();
    end
    expect_out("ready_after_32", S_RDY, 32'd1);
    ra = 5'd3; rb = 5'd20;
    expect_out("dflt_rda", S_RDA, 32'd0);
    expect_out("dflt_rdb", S_RDB, 32'd0);
    expect_out("dflt_busy_b", S_BB, 32'd0);
    compare_now();
    tick();

    // Bypass of a same-cycle write on both ports.
    we = 1'b1; wr = 5'd5; wd = 32'hDEADBEEF; ra = 5'd5; rb = 5'd5;
    expect_out("byp_rda", S_RDA, 32'hDEADBEEF);
    expect_out("byp_rdb", S_RDB, 32'hDEADBEEF);
    expect_out("byp_busy_a", S_BA, 32'd0);
    compare_now();
    tick();
    idle();
    expect_out("stored_rda", S_RDA, 32'hDEADBEEF);
    compare_now();
    tick();
    expect_out("hold_rda", S_RDA, 32'hDEADBEEF);
    expect_out("hold_rdb", S_RDB, 32'hDEADBEEF);
    compare_now();
    tick();

    // Zero register: write and reservation dropped, bypass overridden.
    we = 1'b1; wr = 5'd0; wd = 32'hFFFFFFFF; ra = 5'd0; rb = 5'd0;
    expect_out("zero_byp_rda", S_RDA, 32'd0);
    expect_out("zero_byp_rdb", S_RDB, 32'd0);
    compare_now();
    tick();
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd0;
    expect_out("zero_rda", S_RDA, 32'd0);
    compare_now();
    tick();
    idle();
    expect_out("zero_busy_a", S_BA, 32'd0);
    expect_out("zero_busy_b", S_BB, 32'd0);
    compare_now();
    tick();

    // Reserve 7, then write it back: busy clears in the write cycle.
    rsv_en = 1'b1; rsv_addr = 5'd7;
    compare_now();
    tick();
    idle();
    ra = 5'd7; rb = 5'd8;
    expect_out("rsv7_busy_a", S_BA, 32'd1);
    expect_out("rsv7_busy_b_other", S_BB, 32'd0);
    compare_now();
    tick();
    we = 1'b1; wr = 5'd7; wd = 32'd3;
    expect_out("wb7_busy_a", S_BA, 32'd0);
    expect_out("wb7_rda", S_RDA, 32'd3);
    compare_now();
    tick();
    idle();
    expect_out("wb7_busy_a_after", S_BA, 32'd0);
    expect_out("wb7_rda_after", S_RDA, 32'd3);
    compare_now();
    tick();

    // Write and reserve the same register on one edge: reserve wins.
    we = 1'b1; wr = 5'd9; wd = 32'd1; rsv_en = 1'b1; rsv_addr = 5'd9;
    compare_now();
    tick();
    idle();
    ra = 5'd9; rb = 5'd9;
    expect_out("wr_rsv9_rda", S_RDA, 32'd1);
    expect_out("wr_rsv9_busy_a", S_BA, 32'd1);
    expect_out("wr_rsv9_busy_b", S_BB, 32'd1);
    compare_now();
    tick();

    // Reset from READY: outputs drop during rst, whole file re-zeroed.
    ra = 5'd5; rb = 5'd9;
    rst = 1'b1;
    expect_out("rst2_ready", S_RDY, 32'd0);
    expect_out("rst2_rda", S_RDA, 32'd0);
    expect_out("rst2_busy_b", S_BB, 32'd0);
    compare_now();
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      expect_out("clr2_ready", S_RDY, 32'd0);
      compare_now();
      tick();
    end
    // Reset pulse mid-sweep restarts the sweep from entry 0.
    rst = 1'b1;
    compare_now();
    tick();
    rst = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (k == 5) begin
        we = 1'b1; wr = 5'd12; wd = 32'hAA;
      end else begin
        idle();
      end
      expect_out("clr3_ready", S_RDY, 32'd0);
      compare_now();
      tick();
    end
    idle();
    ra = 5'd12; rb = 5'd5;
    expect_out("ready_after_restart", S_RDY, 32'd1);
    expect_out("ignored_wr12", S_RDA, 32'd0);
    expect_out("rezero_5", S_RDB, 32'd0);
    compare_now();
    tick();
    ra = 5'd7; rb = 5'd9;
    expect_out("rezero_7", S_RDA, 32'd0);
    expect_out("rezero_9", S_RDB, 32'd0);
    expect_out("busy9_cleared", S_BB, 32'd0);
    compare_now();
    tick();

    // Randomised traffic against the reference model.
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i]  = '0;
      busy_m[i] = 1'b0;
    end
    model_on = 1'b1;
    for (int i = 0; i < 150; i++) begin
      ra       = AW'($urandom_range(0, 7));
      rb       = (i % 5 == 0) ? ra : AW'($urandom_range(0, 7));
      wr       = AW'($urandom_range(0, 7));
      wd       = $urandom;
      we       = 1'($urandom_range(0, 1));
      rsv_en   = 1'($urandom_range(0, 1));
      rsv_addr = AW'($urandom_range(0, 7));
      if (we && rsv_en && rsv_addr == wr) rsv_en = 1'b0;
      expect_model();
      compare_now();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
